rx_serial_to_parallel: RTL and testbench
========================================

# rx_serial_to_parallel

Receive-side serial-to-parallel converter: deserialises a 1-bit MSB-first stream into bytes and locks byte alignment on a run of COM (0xBC) symbols. It produces the byte/valid pair consumed by the downstream 1x2 byte demux. Once active, IDLE and COM bytes are presented with valid deasserted, so only payload reaches the lanes.

## Interface
Parameters:
- COM, 8'hBC, alignment/comma symbol
- IDLE, 8'h7C, idle filler symbol
- COM_COUNT, 4, consecutive aligned COM bytes required to go active (range 1..15)

Ports:
- clk  input  1  bit clock; one serial bit sampled per rising edge
- reset  input  1  synchronous, active-high
- serial_in  input  1  serial data, MSB first
- data_out  output  8  last completed byte (registered)
- valid_out  output  1  data_out holds payload (registered)
- byte_strobe  output  1  one-cycle pulse when data_out updates
- active  output  1  alignment locked

## Operation
- byte_now = {shreg[6:0], serial_in}; shreg <= byte_now every edge, all states.
- States: HUNT, ALIGN, ACTIVE; 3-bit bit_cnt; 4-bit com_cnt.
- HUNT: compare byte_now to COM every edge. On match: bit_cnt <= 0, com_cnt <= 1; if COM_COUNT == 1 go ACTIVE, else ALIGN. No match: stay.
- ALIGN: bit_cnt increments each edge, wrapping 7->0. Byte boundary = edge with bit_cnt == 7.
  - At boundary, byte_now == COM: com_cnt++; reaching COM_COUNT enters ACTIVE.
  - At boundary, byte_now != COM: return to HUNT, com_cnt <= 0. HUNT does not compare byte_now on that same edge.
- ACTIVE: at each boundary, data_out <= byte_now and byte_strobe <= 1.
  - valid_out <= 1 unless byte_now is IDLE or COM, in which case 0.
  - Between boundaries: byte_strobe = 0; data_out and valid_out hold.
  - ACTIVE is left only by reset.
- active = (state == ACTIVE), registered.
- Outputs stay 0 in HUNT/ALIGN; data_out does not change before ACTIVE.

## Timing
- Reset values: data_out 8'h00, valid_out 0, byte_strobe 0, active 0, state HUNT, shreg 0, bit_cnt 0, com_cnt 0.
- Reset mid-operation: all of the above on the next edge; alignment must be reacquired from HUNT.
- Latency: a byte's last bit is sampled at edge N; data_out/valid_out/byte_strobe reflect it after edge N (visible cycle N+1).
- active rises on the edge that samples the last bit of the COM_COUNT-th COM; byte_strobe does not fire for that COM.
- Byte period: exactly 8 clk once aligned; strobes are never adjacent.
- Serial COMs at any bit offset are found; the first match fixes the byte phase.
- Simultaneous reset and boundary: reset wins.

## Structure
- Shared package rx_pkg holds COM and IDLE constants and the state enum (HUNT, ALIGN, ACTIVE), shared with the demux and other RX stages.
- Single module, no sub-module. Optional small comparator function in rx_pkg: is_com / is_idle.

## Test plan
- Reset, then 4 x 0xBC, then 0xA5: active rises on the 32nd bit edge; 8 edges later data_out=0xA5, valid_out=1, one-cycle byte_strobe.
- 3 bits of junk (101), then 4 x 0xBC, then 0x3C: alignment at 3-bit offset; data_out=0x3C, valid_out=1.
- 3 x 0xBC, 0x00, 4 x 0xBC, 0x11: no active after the first run; active after the second run; data_out=0x11.
- Active, then 0x7C, 0xBC, 0x55: data_out 0x7C valid 0; 0xBC valid 0; 0x55 valid 1; strobe each byte.
- Active, reset asserted mid-byte for 1 cycle, then 0xA5 without COMs: all outputs 0, active stays 0.
- COM_COUNT=1 build: single 0xBC then 0x0F → active after the 0xBC; data_out=0x0F, valid_out=1.

Source files
------------

// File: rtl/rx_pkg.sv
// ----------------------------------------------------------------------------
// rx_pkg
// Shared definitions for the receive path: the special line symbols and the
// byte-alignment state encoding. Imported by the serial-to-parallel converter,
// the 1x2 byte demux and the other RX stages.
// ----------------------------------------------------------------------------
package rx_pkg;

    // Alignment / comma symbol. A run of these on byte boundaries locks the
    // receiver's byte phase.
    localparam logic [7:0] COM_SYM  = 8'hBC;

    // Idle filler symbol. Never forwarded as payload.
    localparam logic [7:0] IDLE_SYM = 8'h7C;

    // Byte-alignment states.
    //   HUNT   : bit-by-bit search for a COM at any offset
    //   ALIGN  : phase fixed, counting consecutive COMs on byte boundaries
    //   ACTIVE : locked; every 8th bit completes a byte (left only by reset)
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } rx_state_t;

endpackage : rx_pkg

// File: rtl/rx_serial_to_parallel.sv
// ----------------------------------------------------------------------------
// rx_serial_to_parallel
// Deserialises a 1-bit MSB-first stream into bytes. Byte alignment is acquired
// by finding a COM at any bit offset and then seeing COM_COUNT consecutive COMs
// on the same byte phase. Once locked, every completed byte is presented on
// data_out with a one-cycle byte_strobe; IDLE and COM bytes carry valid_out=0
// so only payload reaches the downstream demux lanes.
//
// Parameters:
//   COM        alignment / comma symbol           (default 8'hBC)
//   IDLE       idle filler symbol                 (default 8'h7C)
//   COM_COUNT  consecutive aligned COMs to lock   (1..15, default 4)
//
// Ports:
//   clk          in   bit clock, one serial bit sampled per rising edge
//   reset        in   synchronous, active-high
//   serial_in    in   serial data, MSB first
//   data_out     out  [7:0] last completed byte (registered)
//   valid_out    out  data_out holds payload (registered)
//   byte_strobe  out  one-cycle pulse when data_out updates
//   active       out  alignment locked (registered)
// ----------------------------------------------------------------------------
module rx_serial_to_parallel
    import rx_pkg::*;
#(
    parameter logic [7:0] COM       = COM_SYM,
    parameter logic [7:0] IDLE      = IDLE_SYM,
    parameter int         COM_COUNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
);

    localparam logic [3:0] COM_COUNT_L = 4'(COM_COUNT);

    logic [7:0] shreg_reg;
    logic [2:0] bit_cnt_reg;
    logic [3:0] com_cnt_reg;
    rx_state_t  state_reg;

    // The byte that would be complete if this edge were a byte boundary:
    // the last seven sampled bits plus the bit being sampled now.
    logic [7:0] byte_now;
    logic       boundary;
    logic       now_is_com;
    logic       now_is_idle;

    assign byte_now    = {shreg_reg[6:0], serial_in};
    assign boundary    = (bit_cnt_reg == 3'd7);
    assign now_is_com  = (byte_now == COM);
    assign now_is_idle = (byte_now == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_reg   <= 8'h00;
            bit_cnt_reg <= 3'd0;
            com_cnt_reg <= 4'd0;
            state_reg   <= HUNT;
            data_out    <= 8'h00;
            valid_out   <= 1'b0;
            byte_strobe <= 1'b0;
            active      <= 1'b0;
        end else begin
            // The shift register runs in every state so a byte is always
            // available regardless of where alignment stands.
            shreg_reg   <= byte_now;
            byte_strobe <= 1'b0;

            case (state_reg)
                HUNT: begin
                    // The first COM seen at any offset fixes the byte phase:
                    // clearing bit_cnt here puts the next boundary 8 edges on.
                    if (now_is_com) begin
                        bit_cnt_reg <= 3'd0;
                        com_cnt_reg <= 4'd1;
                        if (COM_COUNT == 1) begin
                            state_reg <= ACTIVE;
                            active    <= 1'b1;
                        end else begin
                            state_reg <= ALIGN;
                        end
                    end
                end

                ALIGN: begin
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                    if (boundary) begin
                        if (now_is_com) begin
                            com_cnt_reg <= com_cnt_reg + 4'd1;
                            if (com_cnt_reg + 4'd1 == COM_COUNT_L) begin
                                state_reg <= ACTIVE;
                                active    <= 1'b1;
                            end
                        end else begin
                            // Broken COM run: resume the bit-level search on
                            // the following edge.
                            state_reg   <= HUNT;
                            com_cnt_reg <= 4'd0;
                            bit_cnt_reg <= 3'd0;
                        end
                    end
                end

                ACTIVE: begin
                    // bit_cnt wrapped to 0 on the locking edge, so boundaries
                    // keep the phase established in HUNT.
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                    if (boundary) begin
                        data_out    <= byte_now;
                        byte_strobe <= 1'b1;
                        valid_out   <= !(now_is_idle || now_is_com);
                    end
                end

                default: begin
                    state_reg <= HUNT;
                end
            endcase
        end
    end

endmodule : rx_serial_to_parallel

// File: tb/tb_rx_serial_to_parallel.sv
// ----------------------------------------------------------------------------
// tb_rx_serial_to_parallel
// Two instances share one serial stream: one locks after four COMs, the other
// after a single COM. Each stimulus segment starts with a one-cycle reset, its
// bit list is run through a stream-level reference model that predicts the
// lock edge and every byte delivered afterwards, and those predictions are
// queued. A monitor compares the DUT outputs against the queues every cycle.
// ----------------------------------------------------------------------------
module tb_rx_serial_to_parallel;

    localparam logic [7:0] TB_COM  = 8'hBC;
    localparam logic [7:0] TB_IDLE = 8'h7C;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       serial_in = 1'b0;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b, strobe_a, strobe_b, active_a, active_b;

    always #5 clk = ~clk;

    rx_serial_to_parallel #(.COM_COUNT(4)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .serial_in  (serial_in),
        .data_out   (data_a),
        .valid_out  (valid_a),
        .byte_strobe(strobe_a),
        .active     (active_a)
    );

    rx_serial_to_parallel #(.COM_COUNT(1)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .serial_in  (serial_in),
        .data_out   (data_b),
        .valid_out  (valid_b),
        .byte_strobe(strobe_b),
        .active     (active_b)
    );

    typedef struct {
        int         edge_i;
        logic [7:0] data;
        logic       valid;
    } ev_t;

    int   checks   = 0;
    int   failures = 0;
    ev_t  exp_a[$];
    ev_t  exp_b[$];
    ev_t  model_ev[$];
    bit   stim[$];
    int   act_a    = -1;
    int   act_b    = -1;
    int   cur_edge = 0;
    bit   in_seg   = 1'b0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (edge %0d)",
                     name, act, req, cur_edge);
        end
    endfunction

    // The 8 bits ending at edge e; bits before the segment are the zeros
    // left in the shift register by reset.
    function automatic logic [7:0] win(input int e);
        logic [7:0] w = 8'h00;
        for (int k = 7; k >= 0; k--) begin
            w = {w[6:0], (e - k >= 0) ? stim[e - k] : 1'b0};
        end
        return w;
    endfunction

    // Stream-level model: scan for a COM window, then require n-1 further COMs
    // at 8-bit strides; a broken run resumes scanning one bit after the break.
    // Once locked, every 8th window is a delivered byte.
    task automatic model_run(input int n, output int act_edge);
        int e;
        int p;
        int cnt;
        int len;
        logic [7:0] w;
        len = stim.size();
        model_ev.delete();
        act_edge = -1;
        e = 0;
        while (e < len && act_edge < 0) begin
            if (win(e) == TB_COM) begin
                cnt = 1;
                p   = e;
                while (cnt < n && p + 8 < len && win(p + 8) == TB_COM) begin
                    p += 8;
                    cnt++;
                end
                if (cnt == n)        act_edge = p;
                else if (p + 8 < len) e = p + 9;
                else                  e = len;
            end else begin
                e++;
            end
        end
        if (act_edge >= 0) begin
            for (int b = act_edge + 8; b < len; b += 8) begin
                w = win(b);
                model_ev.push_back('{b, w, !(w == TB_IDLE || w == TB_COM)});
            end
        end
    endtask

    task automatic add_byte(input logic [7:0] b);
        for (int k = 7; k >= 0; k--) stim.push_back(b[k]);
    endtask

    task automatic add_bits(input logic [7:0] v, input int n);
        for (int k = n - 1; k >= 0; k--) stim.push_back(v[k]);
    endtask

    task automatic mon(input bit which, input logic [7:0] d, input logic v,
                       input logic s, input logic a);
        string tag;
        int    ae;
        bit    exp_act;
        bit    have;
        bit    exp_strobe;
        ev_t   head;
        tag = which ? "B" : "A";
        ae  = which ? act_b : act_a;
        exp_act = (ae >= 0) && (cur_edge >= ae);
        check($sformatf("%s_active", tag), {31'd0, a}, {31'd0, exp_act});
        if (!exp_act) begin
            check($sformatf("%s_outputs_before_lock", tag),
                  {22'd0, d, v, s}, 32'd0);
        end else begin
            have = which ? (exp_b.size() > 0) : (exp_a.size() > 0);
            if (have) head = which ? exp_b[0] : exp_a[0];
            exp_strobe = have && (head.edge_i == cur_edge);
            check($sformatf("%s_strobe", tag), {31'd0, s}, {31'd0, exp_strobe});
            if (exp_strobe) begin
                if (which) void'(exp_b.pop_front());
                else       void'(exp_a.pop_front());
                if (s) begin
                    check($sformatf("%s_data", tag), {24'd0, d}, {24'd0, head.data});
                    check($sformatf("%s_valid", tag), {31'd0, v}, {31'd0, head.valid});
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (in_seg) begin
                mon(1'b0, data_a, valid_a, strobe_a, active_a);
                mon(1'b1, data_b, valid_b, strobe_b, active_b);
            end
        end
    end

    // Reset for one cycle, predict the segment, drive it, confirm every
    // predicted byte was delivered.
    task automatic run_seg();
        @(negedge clk);
        reset     = 1'b1;
        serial_in = 1'($urandom);
        in_seg    = 1'b0;
        @(posedge clk);
        #1;
        check("A_reset", {20'd0, data_a, valid_a, strobe_a, active_a}, 32'd0);
        check("B_reset", {20'd0, data_b, valid_b, strobe_b, active_b}, 32'd0);
        model_run(4, act_a);
        foreach (model_ev[i]) exp_a.push_back(model_ev[i]);
        model_run(1, act_b);
        foreach (model_ev[i]) exp_b.push_back(model_ev[i]);
        for (int e = 0; e < stim.size(); e++) begin
            @(negedge clk);
            reset     = 1'b0;
            serial_in = stim[e];
            cur_edge  = e;
            in_seg    = 1'b1;
        end
        @(negedge clk);
        in_seg = 1'b0;
        check("A_bytes_outstanding", exp_a.size(), 32'd0);
        check("B_bytes_outstanding", exp_b.size(), 32'd0);
        exp_a.delete();
        exp_b.delete();
        stim.delete();
    endtask

    initial begin
        logic [7:0] b;
        int         r;

        // Lock on four COMs from bit 0, then one payload byte.
        for (int i = 0; i < 4; i++) add_byte(TB_COM);
        add_byte(8'hA5);
        run_seg();

        // Three junk bits shift the byte phase by 3.
        add_bits(8'b101, 3);
        for (int i = 0; i < 4; i++) add_byte(TB_COM);
        add_byte(8'h3C);
        run_seg();

        // A broken COM run must not lock; the second full run does.
        for (int i = 0; i < 3; i++) add_byte(TB_COM);
        add_byte(8'h00);
        for (int i = 0; i < 4; i++) add_byte(TB_COM);
        add_byte(8'h11);
        run_seg();

        // IDLE and COM are strobed but not valid; payload is valid.
        for (int i = 0; i < 4; i++) add_byte(TB_COM);
        add_byte(TB_IDLE);
        add_byte(TB_COM);
        add_byte(8'h55);
        run_seg();

        // Lock, then stop mid-byte; the next segment's reset lands mid-byte
        // and a COM-free stream must never lock again.
        for (int i = 0; i < 4; i++) add_byte(TB_COM);
        add_byte(8'hA5);
        add_bits(8'b110, 3);
        run_seg();
        add_byte(8'hA5);
        add_byte(8'hA5);
        run_seg();

        // Single COM then payload (locks the COM_COUNT=1 instance only).
        add_byte(TB_COM);
        add_byte(8'h0F);
        run_seg();

        // Randomised segments: random offset, random COM run length, payload
        // biased toward IDLE and COM, ragged tail.
        for (int s = 0; s < 24; s++) begin
            add_bits(8'($urandom), $urandom_range(0, 7));
            r = $urandom_range(0, 5);
            for (int i = 0; i < r; i++) add_byte(TB_COM);
            for (int i = 0; i < 6; i++) begin
                r = $urandom_range(0, 99);
                if (r < 25)      b = TB_IDLE;
                else if (r < 40) b = TB_COM;
                else             b = 8'($urandom);
                add_byte(b);
            end
            add_bits(8'($urandom), $urandom_range(0, 7));
            run_seg();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rx_serial_to_parallel
